// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift left/right (serial fill or rotate),
// parallel load, plus a counted burst-shift mode with busy/done handshake.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, BURST} state_t;
  typedef enum logic [1:0] {
    M_HOLD = 2'b00,
    M_SHL  = 2'b01,
    M_SHR  = 2'b10,
    M_LOAD = 2'b11
  } mode_t;

  localparam logic [CNT_W-1:0] ONE = 1;

  state_t           state;
  mode_t            mode_e;
  logic [CNT_W-1:0] rem;
  logic             dir_left;
  logic             rot_l;
  logic [WIDTH-1:0] q_idle_shl;
  logic [WIDTH-1:0] q_idle_shr;
  logic [WIDTH-1:0] q_burst;
  logic             burst_req;

  assign mode_e    = mode_t'(mode);
  assign burst_req = start && (mode_e == M_SHL || mode_e == M_SHR);
  assign sout_msb  = q[WIDTH-1];
  assign sout_lsb  = q[0];

  // Next-value candidates: single-step uses live rot, burst uses latched direction/rot.
  always_comb begin
    q_idle_shl = {q[WIDTH-2:0], rot ? q[WIDTH-1] : sin_lsb};
    q_idle_shr = {rot ? q[0] : sin_msb, q[WIDTH-1:1]};
    if (dir_left) begin
      q_burst = {q[WIDTH-2:0], rot_l ? q[WIDTH-1] : sin_lsb};
    end else begin
      q_burst = {rot_l ? q[0] : sin_msb, q[WIDTH-1:1]};
    end
  end

  // Control FSM and data register; busy/done are registered alongside state.
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      state    <= IDLE;
      rem      <= '0;
      dir_left <= 1'b0;
      rot_l    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (burst_req) begin
            // A zero-length burst completes immediately without shifting.
            if (cnt != '0) begin
              state    <= BURST;
              rem      <= cnt;
              dir_left <= (mode_e == M_SHL);
              rot_l    <= rot;
              busy     <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else if (en) begin
            case (mode_e)
              M_SHL:   q <= q_idle_shl;
              M_SHR:   q <= q_idle_shr;
              M_LOAD:  q <= d;
              default: q <= q;
            endcase
          end
        end
        BURST: begin
          q   <= q_burst;
          rem <= rem - ONE;
          if (rem == ONE) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: expectations queued at drive time,
// popped and checked one cycle later, after the edge.
module tb_univ_shift_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       rot;
  logic       sin_lsb;
  logic       sin_msb;
  logic [7:0] d;
  logic       start;
  logic [3:0] cnt;
  logic [7:0] q;
  logic       sout_msb;
  logic       sout_lsb;
  logic       busy;
  logic       done;

  logic [11:0] exp_q[$];
  string       tag_q[$];
  int          tests;
  int          failed;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot),
    .sin_lsb(sin_lsb), .sin_msb(sin_msb), .d(d), .start(start), .cnt(cnt),
    .q(q), .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    logic [11:0] e;
    logic [11:0] got;
    string       t;
    exp_q.push_back({eq, eq[7], eq[0], eb, ed});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    got = {q, sout_msb, sout_lsb, busy, done};
    tests++;
    assert (got === e) else begin
      failed++;
      $error("FAIL %s: got q=%h so=%b%b busy=%b done=%b, expected q=%h so=%b%b busy=%b done=%b",
             t, got[11:4], got[3], got[2], got[1], got[0], e[11:4], e[3], e[2], e[1], e[0]);
    end
  endtask

  task automatic idle_inputs();
    en = 1'b0; mode = 2'b00; rot = 1'b0; sin_lsb = 1'b0; sin_msb = 1'b0;
    d = 8'h00; start = 1'b0; cnt = 4'd0;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b1;
    idle_inputs();
    en = 1'b1; mode = 2'b11; d = 8'hFF;
    step("reset", 8'h00, 1'b0, 1'b0);

    // Single-step operations
    rst = 1'b0;
    en = 1'b1; mode = 2'b11; d = 8'hA5;
    step("load_a5", 8'hA5, 1'b0, 1'b0);
    mode = 2'b01; rot = 1'b0; sin_lsb = 1'b1;
    step("shl_fill1", 8'h4B, 1'b0, 1'b0);
    mode = 2'b10; sin_msb = 1'b0;
    step("shr_fill0", 8'h25, 1'b0, 1'b0);
    en = 1'b0; mode = 2'b01;
    step("en0_hold", 8'h25, 1'b0, 1'b0);
    en = 1'b1; mode = 2'b00;
    step("mode_hold", 8'h25, 1'b0, 1'b0);
    mode = 2'b11; d = 8'h81;
    step("load_81", 8'h81, 1'b0, 1'b0);
    mode = 2'b01; rot = 1'b1; sin_lsb = 1'b0;
    step("rotl", 8'h03, 1'b0, 1'b0);
    mode = 2'b11; d = 8'h81;
    step("load_81b", 8'h81, 1'b0, 1'b0);
    mode = 2'b10; rot = 1'b1; sin_msb = 1'b0;
    step("rotr", 8'hC0, 1'b0, 1'b0);
    rot = 1'b0; sin_msb = 1'b1;
    step("shr_fill1", 8'hE0, 1'b0, 1'b0);

    // Burst of 3 left rotates; other inputs toggled to prove they are ignored
    mode = 2'b11; d = 8'h01;
    step("load_01", 8'h01, 1'b0, 1'b0);
    idle_inputs();
    start = 1'b1; mode = 2'b01; rot = 1'b1; cnt = 4'd3;
    step("burst_start", 8'h01, 1'b1, 1'b0);
    start = 1'b0; en = 1'b1; mode = 2'b11; d = 8'hFF; rot = 1'b0; sin_lsb = 1'b1; cnt = 4'd9;
    step("burst_s1", 8'h02, 1'b1, 1'b0);
    step("burst_s2", 8'h04, 1'b1, 1'b0);
    idle_inputs();
    step("burst_done", 8'h08, 1'b0, 1'b1);
    step("burst_after", 8'h08, 1'b0, 1'b0);

    // Zero-length burst: start outranks en/mode, done next cycle, no busy
    start = 1'b1; en = 1'b1; mode = 2'b01; sin_lsb = 1'b1; cnt = 4'd0;
    step("zero_done", 8'h08, 1'b0, 1'b1);
    idle_inputs();
    step("zero_after", 8'h08, 1'b0, 1'b0);

    // Start with load mode is ignored; load proceeds
    start = 1'b1; en = 1'b1; mode = 2'b11; d = 8'h3C; cnt = 4'd2;
    step("start_load", 8'h3C, 1'b0, 1'b0);
    idle_inputs();
    step("start_load_after", 8'h3C, 1'b0, 1'b0);

    // Reset mid-burst aborts without done
    en = 1'b1; mode = 2'b11; d = 8'h01;
    step("load_01b", 8'h01, 1'b0, 1'b0);
    idle_inputs();
    start = 1'b1; mode = 2'b01; cnt = 4'd5;
    step("abort_start", 8'h01, 1'b1, 1'b0);
    idle_inputs();
    step("abort_s1", 8'h02, 1'b1, 1'b0);
    step("abort_s2", 8'h04, 1'b1, 1'b0);
    rst = 1'b1;
    step("abort_rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    step("abort_quiet1", 8'h00, 1'b0, 1'b0);
    step("abort_quiet2", 8'h00, 1'b0, 1'b0);

    // Back-to-back bursts, second start issued in the done cycle
    en = 1'b1; mode = 2'b11; d = 8'h81;
    step("load_81c", 8'h81, 1'b0, 1'b0);
    idle_inputs();
    start = 1'b1; mode = 2'b10; rot = 1'b0; sin_msb = 1'b1; cnt = 4'd2;
    step("b2b_start1", 8'h81, 1'b1, 1'b0);
    start = 1'b0;
    step("b2b_a1", 8'hC0, 1'b1, 1'b0);
    step("b2b_done1", 8'hE0, 1'b0, 1'b1);
    start = 1'b1; mode = 2'b10; rot = 1'b1; cnt = 4'd2;
    step("b2b_start2", 8'hE0, 1'b1, 1'b0);
    start = 1'b0; rot = 1'b0;
    step("b2b_b1", 8'h70, 1'b1, 1'b0);
    step("b2b_done2", 8'h38, 1'b0, 1'b1);
    idle_inputs();
    step("b2b_after", 8'h38, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 Parameter CNT_W, default 4, width of burst count; bursts up to 2^CNT_W-1 shifts.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-005 en  input  1  single-step enable; gates mode operations in IDLE.
REQ-006 mode  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load.
REQ-007 rot  input  1  1 = rotate (vacated bit from opposite end), 0 = serial fill.
REQ-008 sin_lsb  input  1  serial bit entering bit 0 on left shift (rot=0).
REQ-009 sin_msb  input  1  serial bit entering bit WIDTH-1 on right shift (rot=0).
REQ-010 d  input  WIDTH  parallel load data.
REQ-011 start  input  1  burst request; one-cycle pulse, sampled only in IDLE.
REQ-012 cnt  input  CNT_W  number of shifts for the burst.
REQ-013 q  output  WIDTH  register contents.
REQ-014 sout_msb  output  1  equals q[WIDTH-1], combinational from q.
REQ-015 sout_lsb  output  1  equals q[0], combinational from q.
REQ-016 busy  output  1  high while a burst is executing.
REQ-017 done  output  1  one-cycle pulse on burst completion.

Function
REQ-018 States IDLE and BURST; reset state IDLE.
REQ-019 IDLE, start=0, en=1: mode applied at the edge; shift left q<={q[W-2:0], rot?q[W-1]:sin_lsb}; shift right q<={rot?q[0]:sin_msb, q[W-1:1]}; load q<=d; hold q unchanged.
REQ-020 IDLE, start=0, en=0: q unchanged regardless of mode.
REQ-021 IDLE, start=1, mode in {01,10}, cnt!=0: latch direction, rot and cnt; q unchanged this edge; go BURST; busy=1 from next cycle; start has priority over en/mode.
REQ-022 IDLE, start=1, cnt=0 (mode 01/10): no shift, stay IDLE, busy stays 0, done=1 next cycle.
REQ-023 IDLE, start=1, mode in {00,11}: start ignored, and en/mode processed as REQ-019/020.
REQ-024 BURST: one shift per cycle in latched direction using latched rot; sin_lsb/sin_msb sampled live each cycle; remaining count decremented each shift.
REQ-025 BURST: en, mode, d, start, cnt, rot ignored.
REQ-026 Exactly cnt shifts occur, on the cnt edges following the start edge; busy high for exactly cnt cycles.
REQ-027 The edge performing the last shift returns to IDLE and sets done=1 for one cycle (busy=0 in that cycle).
REQ-028 done never asserted except per REQ-022/027; never two consecutive cycles from one burst.
REQ-029 A start in the cycle done is high is accepted normally (back-to-back bursts, no idle gap required).

Reset
REQ-030 rst=1 at an edge: q=0, state IDLE, busy=0, done=0, remaining count=0; overrides all other inputs.
REQ-031 rst mid-burst aborts it: no further shifts, no done pulse.
REQ-032 First operation accepted on the first edge with rst=0.

Verification
REQ-033 Load/step: en=1, mode=11, d=8'hA5 -> q=A5; then mode=01, rot=0, sin_lsb=1 -> q=4B; mode=10, sin_msb=0 -> q=25.
REQ-034 Rotate: q=8'h81, en=1, mode=01, rot=1 -> q=03; mode=10, rot=1 from 81 -> q=C0.
REQ-035 Burst: q=8'h01, start, mode=01, rot=1, cnt=3 -> busy high 3 cycles, q=02,04,08, done one cycle with q=08, busy=0.
REQ-036 Zero and ignored: start, cnt=0 -> done next cycle, busy never high, q unchanged; start with mode=11 -> loads d, no busy/done.
REQ-037 Reset mid-burst: cnt=5, rst after 2nd shift -> q=00, busy=0, done never pulses; en=0 during burst does not stall it.
REQ-038 Back-to-back: start (cnt=2) again in the done cycle -> second burst runs 2 shifts, busy low only for that done cycle.
